// File: rtl/tl_line_master.sv
// Whole-line TileLink master: one Get or a BEATS-beat PutFullData per request, D beats gathered into a line.
// A fields are zero whenever a_valid is low; rsp_* and ready outputs come straight from state registers.
module tl_line_master #(
    parameter int LINE_SIZE_LOG2 = 6,
    parameter int SOURCE_ID      = 0,
    localparam int LINE_BITS     = 8 << LINE_SIZE_LOG2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [31:0]          req_addr,
    input  logic [LINE_BITS-1:0] req_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_wr,
    output logic [LINE_BITS-1:0] rsp_data,
    output logic                 rsp_err,
    output logic [2:0]           tlmst_a_opcode,
    output logic [2:0]           tlmst_a_param,
    output logic [7:0]           tlmst_a_size,
    output logic [2:0]           tlmst_a_source,
    output logic [31:0]          tlmst_a_address,
    output logic [15:0]          tlmst_a_mask,
    output logic [127:0]         tlmst_a_data,
    output logic                 tlmst_a_corrupt,
    output logic                 tlmst_a_valid,
    input  logic                 tlmst_a_ready,
    input  logic [2:0]           tlmst_d_opcode,
    input  logic [1:0]           tlmst_d_param,
    input  logic [7:0]           tlmst_d_size,
    input  logic [2:0]           tlmst_d_source,
    input  logic [2:0]           tlmst_d_sink,
    input  logic                 tlmst_d_denied,
    input  logic [127:0]         tlmst_d_data,
    input  logic                 tlmst_d_corrupt,
    input  logic                 tlmst_d_valid,
    output logic                 tlmst_d_ready
);
    localparam int BEATS = 1 << (LINE_SIZE_LOG2 - 4);
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IW    = LINE_SIZE_LOG2 + 3;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
    localparam logic [31:0]   ADDR_LOW  = (32'd1 << LINE_SIZE_LOG2) - 32'd1;

    typedef enum logic [1:0] {IDLE, A_SEND, D_WAIT, RESP} state_t;

    state_t                state_q;
    logic [BW-1:0]         beat_cnt_q;
    logic                  err_q;
    logic                  wr_q;
    logic [31:0]           addr_q;
    logic [LINE_BITS-1:0]  line_q;
    logic [IW-1:0]         slot;
    logic                  a_active;
    logic                  d_bad;

    // One buffer serves both directions: writeback source and refill destination.
    assign slot     = IW'({beat_cnt_q, 7'd0});
    assign a_active = (state_q == A_SEND);
    assign d_bad    = tlmst_d_denied | tlmst_d_corrupt |
                      (tlmst_d_opcode != (wr_q ? 3'd0 : 3'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            line_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    wr_q       <= req_wr;
                    addr_q     <= req_addr & ~ADDR_LOW;
                    line_q     <= req_data;
                    beat_cnt_q <= '0;
                    err_q      <= 1'b0;
                    state_q    <= A_SEND;
                end
                A_SEND: if (tlmst_a_ready) begin
                    if (!wr_q) begin
                        state_q <= D_WAIT;
                    end else if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_q <= '0;
                        state_q    <= D_WAIT;
                    end else begin
                        beat_cnt_q <= beat_cnt_q + 1'b1;
                    end
                end
                D_WAIT: if (tlmst_d_valid) begin
                    err_q <= err_q | d_bad;
                    if (wr_q) begin
                        state_q <= RESP;
                    end else begin
                        line_q[slot +: 128] <= tlmst_d_data;
                        if (beat_cnt_q == LAST_BEAT) state_q <= RESP;
                        else beat_cnt_q <= beat_cnt_q + 1'b1;
                    end
                end
                RESP: if (rsp_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign rsp_valid     = (state_q == RESP);
    assign rsp_wr        = wr_q;
    assign rsp_data      = line_q;
    assign rsp_err       = err_q;
    assign tlmst_d_ready = (state_q == D_WAIT);

    assign tlmst_a_valid   = a_active;
    assign tlmst_a_opcode  = a_active ? (wr_q ? 3'd0 : 3'd4) : 3'd0;
    assign tlmst_a_param   = 3'd0;
    assign tlmst_a_size    = a_active ? 8'(LINE_SIZE_LOG2) : 8'd0;
    assign tlmst_a_source  = a_active ? 3'(SOURCE_ID) : 3'd0;
    assign tlmst_a_address = a_active ? addr_q : 32'd0;
    assign tlmst_a_mask    = a_active ? 16'hFFFF : 16'h0000;
    assign tlmst_a_data    = (a_active && wr_q) ? line_q[slot +: 128] : 128'd0;
    assign tlmst_a_corrupt = 1'b0;

    logic unused_d_fields;
    assign unused_d_fields = ^{tlmst_d_param, tlmst_d_size, tlmst_d_source, tlmst_d_sink};
endmodule

// File: tb/tb_tl_line_master.sv
module tb_tl_line_master;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         req_valid, req_ready, req_wr;
    logic [31:0]  req_addr;
    logic [511:0] req_data;
    logic         rsp_valid, rsp_ready, rsp_wr, rsp_err;
    logic [511:0] rsp_data;
    logic [2:0]   a_opcode, a_param, a_source;
    logic [7:0]   a_size;
    logic [31:0]  a_address;
    logic [15:0]  a_mask;
    logic [127:0] a_data;
    logic         a_corrupt, a_valid, a_ready;
    logic [2:0]   d_opcode, d_source, d_sink;
    logic [1:0]   d_param;
    logic [7:0]   d_size;
    logic         d_denied, d_corrupt, d_valid, d_ready;
    logic [127:0] d_data;

    tl_line_master #(.LINE_SIZE_LOG2(6), .SOURCE_ID(5)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .tlmst_a_opcode(a_opcode), .tlmst_a_param(a_param), .tlmst_a_size(a_size),
        .tlmst_a_source(a_source), .tlmst_a_address(a_address), .tlmst_a_mask(a_mask),
        .tlmst_a_data(a_data), .tlmst_a_corrupt(a_corrupt),
        .tlmst_a_valid(a_valid), .tlmst_a_ready(a_ready),
        .tlmst_d_opcode(d_opcode), .tlmst_d_param(d_param), .tlmst_d_size(d_size),
        .tlmst_d_source(d_source), .tlmst_d_sink(d_sink), .tlmst_d_denied(d_denied),
        .tlmst_d_data(d_data), .tlmst_d_corrupt(d_corrupt),
        .tlmst_d_valid(d_valid), .tlmst_d_ready(d_ready)
    );

    localparam logic [511:0] LINE40  = {{4{32'h80000070}}, {4{32'h80000060}},
                                        {4{32'h80000050}}, {4{32'h80000040}}};
    localparam logic [511:0] LINE300 = {{4{32'h80000330}}, {4{32'h80000320}},
                                        {4{32'h80000310}}, {4{32'h80000300}}};
    localparam logic [511:0] LINE500 = {{4{32'h80000530}}, {4{32'h80000520}},
                                        {4{32'h80000510}}, {4{32'h80000500}}};
    localparam logic [511:0] WB100   = {{16{8'h44}}, {16{8'h33}}, {16{8'h22}}, {16{8'h11}}};
    localparam logic [511:0] WB200   = {{16{8'hDD}}, {16{8'hCC}}, {16{8'hBB}}, {16{8'hAA}}};

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [511:0] wdata;
        logic [3:0]   deny;
        logic [3:0]   badop;
        logic         stall;
        logic [511:0] exp_data;
        logic         exp_err;
    } vec_t;

    int checks = 0;
    int failures = 0;

    // Slave memory: unwritten 16-byte words read back as their own address repeated.
    logic [127:0] mem [logic [31:0]];

    function automatic logic [127:0] memrd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {4{a}};
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_txn(input vec_t v, output logic [511:0] rdata, output logic rerr,
                          output logic rwr);
        logic [31:0]  base;
        logic [127:0] exp_a;
        int k, nb, cyc;
        logic done;
        base  = v.addr & 32'hFFFF_FFC0;
        nb    = v.wr ? 4 : 1;
        rdata = '0;
        rerr  = 1'b0;
        rwr   = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_wr = v.wr; req_addr = v.addr; req_data = v.wdata;
        chk("req_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0; req_data = '0;
        k = 0; cyc = 0;
        while (k < nb && cyc < 200) begin
            a_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (a_valid) begin
                exp_a = v.wr ? v.wdata[128*k +: 128] : 128'd0;
                chk("a_hdr", {a_opcode, a_param, a_size, a_source, a_address, a_mask, a_corrupt},
                    {(v.wr ? 3'd0 : 3'd4), 3'd0, 8'd6, 3'd5, base, 16'hFFFF, 1'b0});
                chk("a_data", a_data, exp_a);
                if (a_ready) begin
                    if (v.wr) mem[base + 32'(16*k)] = exp_a;
                    k++;
                end
            end
            cyc++;
            @(negedge clk);
        end
        a_ready = 1'b0;
        chk("a_beats", k, nb);
        if (!v.stall) chk("a_cycles", cyc, nb);
        chk("d_phase", {a_valid, d_ready}, 2'b01);
        nb = v.wr ? 1 : 4;
        k = 0; cyc = 0;
        while (k < nb && cyc < 200) begin
            d_valid  = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            d_opcode = (v.wr || v.badop[k]) ? 3'd0 : 3'd1;
            d_denied = v.deny[k];
            d_data   = v.wr ? 128'd0 : memrd(base + 32'(16*k));
            if (d_valid && d_ready) k++;
            cyc++;
            @(negedge clk);
        end
        d_valid = 1'b0; d_denied = 1'b0; d_opcode = 3'd0; d_data = '0;
        chk("d_beats", k, nb);
        if (!v.stall) chk("d_cycles", cyc, nb);
        chk("rsp_rise", rsp_valid, 1);
        done = 1'b0; cyc = 0;
        while (!done && cyc < 200) begin
            rsp_ready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rsp_valid && rsp_ready) begin
                rdata = rsp_data; rerr = rsp_err; rwr = rsp_wr; done = 1'b1;
            end
            cyc++;
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        chk("rsp_done", done, 1);
        chk("idle_after", {req_ready, rsp_valid}, 2'b10);
    endtask

    vec_t         vecs [11];
    vec_t         rv;
    logic [511:0] got_data;
    logic         got_err, got_wr;

    initial begin
        vecs[0]  = '{1'b0, 32'h80000044, '0,    4'b0000, 4'b0000, 1'b0, LINE40,  1'b0};
        vecs[1]  = '{1'b1, 32'h80000100, WB100, 4'b0000, 4'b0000, 1'b0, '0,      1'b0};
        vecs[2]  = '{1'b0, 32'h8000010C, '0,    4'b0000, 4'b0000, 1'b0, WB100,   1'b0};
        vecs[3]  = '{1'b0, 32'h80000044, '0,    4'b0000, 4'b0000, 1'b1, LINE40,  1'b0};
        vecs[4]  = '{1'b1, 32'h80000200, WB200, 4'b0000, 4'b0000, 1'b1, '0,      1'b0};
        vecs[5]  = '{1'b0, 32'h8000023F, '0,    4'b0000, 4'b0000, 1'b1, WB200,   1'b0};
        vecs[6]  = '{1'b0, 32'h80000044, '0,    4'b0100, 4'b0000, 1'b0, LINE40,  1'b1};
        vecs[7]  = '{1'b0, 32'h80000044, '0,    4'b0000, 4'b0010, 1'b0, LINE40,  1'b1};
        vecs[8]  = '{1'b0, 32'h80000300, '0,    4'b0000, 4'b0000, 1'b0, LINE300, 1'b0};
        vecs[9]  = '{1'b1, 32'h80000400, WB200, 4'b0001, 4'b0000, 1'b0, '0,      1'b1};
        vecs[10] = '{1'b0, 32'h80000400, '0,    4'b0000, 4'b0000, 1'b1, WB200,   1'b0};

        rst = 1'b1;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_data = '0;
        rsp_ready = 1'b0; a_ready = 1'b0;
        d_opcode = '0; d_param = '0; d_size = 8'd6; d_source = 3'd5; d_sink = '0;
        d_denied = 1'b0; d_corrupt = 1'b0; d_data = '0; d_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", {a_valid, d_ready, rsp_valid, rsp_err, req_ready}, 5'b00001);
        chk("rst_a_fields", {a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
                             a_corrupt}, '0);
        rst = 1'b0;

        d_valid = 1'b1; d_opcode = 3'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stray_d", {d_ready, req_ready, a_valid, rsp_valid}, 4'b0100);
        end
        d_valid = 1'b0; d_opcode = 3'd0;

        for (int i = 0; i < 11; i++) begin
            do_txn(vecs[i], got_data, got_err, got_wr);
            chk($sformatf("v%0d_rsp_wr", i), got_wr, vecs[i].wr);
            if (!vecs[i].wr) chk($sformatf("v%0d_rsp_data", i), got_data, vecs[i].exp_data);
            chk($sformatf("v%0d_rsp_err", i), got_err, vecs[i].exp_err);
        end

        // Abandon a writeback after its second beat.
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h80000500; req_data = WB100;
        @(negedge clk);
        req_valid = 1'b0; a_ready = 1'b1;
        chk("mid_a_valid", a_valid, 1);
        @(negedge clk);
        chk("mid_beat1", a_data, WB100[255:128]);
        @(negedge clk);
        a_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid", {a_valid, rsp_valid, req_ready, d_ready}, 4'b0010);
        rv = '{1'b0, 32'h80000500, '0, 4'b0000, 4'b0000, 1'b0, LINE500, 1'b0};
        do_txn(rv, got_data, got_err, got_wr);
        chk("post_rst_data", got_data, LINE500);
        chk("post_rst_err", got_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
